glyph_renderer: RTL and testbench



---
 rtl/glyph_renderer.sv | 162 ++++++++++++++++
 tb/tb_glyph_renderer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_renderer.sv
// Text-mode pixel stage: maps the raster position to a text cell, reads the character code,
// fetches the glyph row from an external synchronous font ROM and emits an aligned RGB pixel.
module glyph_renderer #(
  parameter int          SCALE        = 8,
  parameter int          CHARA_WIDTH  = 8,
  parameter int          CHARA_HEIGHT = 11,
  parameter int          CORDW        = 16,
  parameter int          COLS         = 10,
  parameter int          ROWS         = 5,
  parameter int          ADDRW        = 6,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] FG           = 12'hFFF,
  parameter logic [11:0] BG           = 12'h000
) (
  input  logic                    clk_pix,
  input  logic                    rst_n,
  input  logic                    de,
  input  logic                    hsync,
  input  logic                    vsync,
  input  logic signed [CORDW-1:0] sx,
  input  logic signed [CORDW-1:0] sy,
  input  logic [3:0]              bitCnt,
  input  logic [3:0]              lineCnt,
  input  logic                    wr_en,
  input  logic [ADDRW-1:0]        wr_addr,
  input  logic [7:0]              wr_data,
  input  logic                    cursor_en,
  input  logic [ADDRW-1:0]        cursor_col,
  input  logic [ADDRW-1:0]        cursor_row,
  output logic [11:0]             font_addr,
  input  logic [CHARA_WIDTH-1:0]  font_data,
  output logic [11:0]             rgb,
  output logic                    de_o,
  output logic                    hsync_o,
  output logic                    vsync_o
);

  localparam int               DEPTH      = COLS * ROWS;
  localparam int               FCW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CORDW-1:0] CELL_W     = CORDW'(CHARA_WIDTH * SCALE);
  localparam logic [CORDW-1:0] CELL_H     = CORDW'(CHARA_HEIGHT * SCALE);
  localparam logic [CORDW-1:0] COLS_C     = CORDW'(COLS);
  localparam logic [CORDW-1:0] ROWS_C     = CORDW'(ROWS);
  localparam logic [ADDRW:0]   DEPTH_C    = (ADDRW + 1)'(DEPTH);
  localparam logic [FCW-1:0]   FRAME_LAST = FCW'(BLINK_FRAMES - 1);

  typedef enum logic {BLINK_OFF = 1'b0, BLINK_ON = 1'b1} blink_t;

  typedef struct packed {
    logic       de;
    logic       hsync;
    logic       vsync;
    logic       in_range;
    logic       cursor_hit;
    logic [3:0] bit_idx;
  } ctrl_t;

  blink_t           blink_phase, blink_next;
  logic [FCW-1:0]   frame_cnt, frame_next;
  logic             vsync_prev, frame_tick, frame_wrap;

  logic [CORDW-1:0] sx_u, sy_u, col, row;
  logic             in_range, cursor_hit;
  logic [ADDRW-1:0] rd_addr;

  logic [7:0]       text_mem [DEPTH];
  logic [7:0]       char_code;

  ctrl_t            ctrl_in, ctrl_s1, ctrl_s2, ctrl_s3;
  logic [3:0]       line_s1;
  logic             glyph_bit, lit;
  logic [11:0]      pixel;

  // Negative coordinates fail the sign test, so their unsigned quotients never matter.
  assign sx_u     = $unsigned(sx);
  assign sy_u     = $unsigned(sy);
  assign col      = sx_u / CELL_W;
  assign row      = sy_u / CELL_H;
  assign in_range = !sx[CORDW-1] && !sy[CORDW-1] && (col < COLS_C) && (row < ROWS_C);
  assign rd_addr  = in_range ? (row[ADDRW-1:0] * ADDRW'(COLS) + col[ADDRW-1:0]) : '0;

  assign cursor_hit = cursor_en && (blink_phase == BLINK_ON) &&
                      (col == CORDW'(cursor_col)) && (row == CORDW'(cursor_row));

  assign ctrl_in = '{de: de, hsync: hsync, vsync: vsync, in_range: in_range,
                     cursor_hit: cursor_hit, bit_idx: bitCnt};

  // Text buffer keeps its contents through reset; a same-edge read sees the old value.
  always_ff @(posedge clk_pix) begin
    if (wr_en && ({1'b0, wr_addr} < DEPTH_C)) begin
      text_mem[wr_addr] <= wr_data;
    end
    char_code <= text_mem[rd_addr];
  end

  assign frame_tick = vsync && !vsync_prev;
  assign frame_wrap = frame_tick && (frame_cnt == FRAME_LAST);

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      blink_phase <= BLINK_OFF;
      frame_cnt   <= '0;
      vsync_prev  <= 1'b0;
    end else begin
      blink_phase <= blink_next;
      frame_cnt   <= frame_next;
      vsync_prev  <= vsync;
    end
  end

  always_comb begin
    blink_next = blink_phase;
    frame_next = frame_cnt;
    if (frame_wrap) begin
      frame_next = '0;
      blink_next = (blink_phase == BLINK_ON) ? BLINK_OFF : BLINK_ON;
    end else if (frame_tick) begin
      frame_next = frame_cnt + 1'b1;
    end
  end

  // Controls ride three stages so they meet the ROM data, which lags font_addr by one cycle.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_s1   <= '0;
      ctrl_s2   <= '0;
      ctrl_s3   <= '0;
      line_s1   <= '0;
      font_addr <= '0;
      rgb       <= '0;
      de_o      <= 1'b0;
      hsync_o   <= 1'b0;
      vsync_o   <= 1'b0;
    end else begin
      ctrl_s1   <= ctrl_in;
      line_s1   <= lineCnt;
      font_addr <= {char_code, line_s1};
      ctrl_s2   <= ctrl_s1;
      ctrl_s3   <= ctrl_s2;
      rgb       <= pixel;
      de_o      <= ctrl_s3.de;
      hsync_o   <= ctrl_s3.hsync;
      vsync_o   <= ctrl_s3.vsync;
    end
  end

  // bitCnt 0 selects the MSB, the leftmost pixel of the glyph row.
  always_comb begin
    glyph_bit = 1'b0;
    for (int i = 0; i < CHARA_WIDTH; i++) begin
      if (ctrl_s3.bit_idx == 4'(i)) begin
        glyph_bit = font_data[CHARA_WIDTH-1-i];
      end
    end
    lit   = glyph_bit ^ ctrl_s3.cursor_hit;
    pixel = 12'h000;
    if (ctrl_s3.de) begin
      pixel = (ctrl_s3.in_range && lit) ? FG : BG;
    end
  end

endmodule

// File: tb/tb_glyph_renderer.sv
// Bench for glyph_renderer: randomized and directed raster stimulus, a text/blink reference
// model and a queue-based scoreboard checked by an independent monitor.
module tb_glyph_renderer;

  localparam int          CORDW = 16;
  localparam int          ADDRW = 6;
  localparam int          NCELL = 50;
  localparam logic [11:0] FG    = 12'hFFF;
  localparam logic [11:0] BG    = 12'h000;

  logic                    clk_pix = 1'b0;
  logic                    rst_n;
  logic                    de, hsync, vsync;
  logic signed [CORDW-1:0] sx, sy;
  logic [3:0]              bitCnt, lineCnt;
  logic                    wr_en;
  logic [ADDRW-1:0]        wr_addr;
  logic [7:0]              wr_data;
  logic                    cursor_en;
  logic [ADDRW-1:0]        cursor_col, cursor_row;
  logic [11:0]             font_addr;
  logic [7:0]              font_data;
  logic [11:0]             rgb;
  logic                    de_o, hsync_o, vsync_o;

  always #5 clk_pix = ~clk_pix;

  glyph_renderer dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .de(de), .hsync(hsync), .vsync(vsync),
    .sx(sx), .sy(sy), .bitCnt(bitCnt), .lineCnt(lineCnt),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .font_addr(font_addr), .font_data(font_data),
    .rgb(rgb), .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o)
  );

  function automatic logic [7:0] rom_fn(input logic [11:0] a);
    logic [11:0] t;
    if (a == 12'h413) return 8'h81;
    t = a * 12'd37 + 12'd11;
    return t[7:0] ^ t[11:4];
  endfunction

  always @(posedge clk_pix) font_data <= rom_fn(font_addr);

  int cyc = 0;
  always @(posedge clk_pix) cyc <= cyc + 1;

  typedef struct {
    logic de, hs, vs;
    int   sx, sy, bitc, line;
    logic wr_en;
    int   wr_addr, wr_data;
    logic cur_en;
    int   cur_col, cur_row;
  } stim_t;

  typedef struct { int due; logic [11:0] rgb; logic de, hs, vs; } pix_exp_t;
  typedef struct { int due; logic [11:0] addr; } fa_exp_t;

  pix_exp_t   pix_q[$];
  fa_exp_t    fa_q[$];
  logic [7:0] model_buf [NCELL];
  int         rises   = 0;
  logic       prev_vs = 1'b0;
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{de: 1'b0, hs: 1'b0, vs: 1'b0, sx: -1, sy: 0, bitc: 0, line: 0,
          wr_en: 1'b0, wr_addr: 0, wr_data: 0, cur_en: 1'b0, cur_col: 0, cur_row: 0};
    return s;
  endfunction

  // Drive one pixel and predict its outputs from the cell/glyph/blink rules.
  task automatic apply_stimulus(input stim_t s);
    logic       in_rng, hit, lit;
    int         col, row;
    logic [7:0] code, glyph;
    logic [11:0] exp_rgb;
    @(negedge clk_pix);
    de = s.de; hsync = s.hs; vsync = s.vs;
    sx = CORDW'(s.sx); sy = CORDW'(s.sy);
    bitCnt = 4'(s.bitc); lineCnt = 4'(s.line);
    wr_en = s.wr_en; wr_addr = ADDRW'(s.wr_addr); wr_data = 8'(s.wr_data);
    cursor_en = s.cur_en; cursor_col = ADDRW'(s.cur_col); cursor_row = ADDRW'(s.cur_row);
    col = s.sx / 64;
    row = s.sy / 88;
    in_rng = (s.sx >= 0) && (s.sy >= 0) && (col < 10) && (row < 5);
    lit = 1'b0;
    if (in_rng) begin
      code  = model_buf[row * 10 + col];
      glyph = rom_fn({code, 4'(s.line)});
      hit   = s.cur_en && (((rises / 30) % 2) == 1) && (col == s.cur_col) && (row == s.cur_row);
      lit   = glyph[7 - s.bitc] ^ hit;
      fa_q.push_back('{due: cyc + 2, addr: {code, 4'(s.line)}});
    end
    exp_rgb = !s.de ? 12'h000 : (in_rng && lit) ? FG : BG;
    pix_q.push_back('{due: cyc + 4, rgb: exp_rgb, de: s.de, hs: s.hs, vs: s.vs});
    if (s.vs && !prev_vs) rises++;
    prev_vs = s.vs;
    if (s.wr_en && s.wr_addr < NCELL) model_buf[s.wr_addr] = 8'(s.wr_data);
  endtask

  // Monitor: compares whatever expectation has come due on this cycle.
  always @(negedge clk_pix) begin
    pix_exp_t pe;
    fa_exp_t  fe;
    if (rst_n) begin
      while (fa_q.size() > 0 && fa_q[0].due <= cyc) begin
        fe = fa_q.pop_front();
        check_output("font_addr", 32'(font_addr), 32'(fe.addr));
      end
      while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
        pe = pix_q.pop_front();
        check_output("rgb", 32'(rgb), 32'(pe.rgb));
        check_output("de_o", 32'(de_o), 32'(pe.de));
        check_output("hsync_o", 32'(hsync_o), 32'(pe.hs));
        check_output("vsync_o", 32'(vsync_o), 32'(pe.vs));
      end
    end
  end

  task automatic readback_all();
    stim_t s;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 10; c++) begin
        s = idle_stim();
        s.de = 1'b1; s.line = int'($urandom_range(0, 10)); s.bitc = int'($urandom_range(0, 7));
        s.sx = c * 64 + int'($urandom_range(0, 63));
        s.sy = r * 88 + int'($urandom_range(0, 87));
        apply_stimulus(s);
      end
    end
  endtask

  int bx [8] = '{640, 640, 639, 0,   0,   -1, 0,  639};
  int by [8] = '{0,   0,   0,   439, 440, 0,  -1, 439};
  int bd [8] = '{1,   0,   1,   1,   1,   1,  1,  1};

  initial begin
    stim_t s;
    rst_n = 1'b0;
    de = 1'b1; hsync = 1'b1; vsync = 1'b1; sx = '0; sy = '0; bitCnt = '0; lineCnt = 4'd3;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
    repeat (4) @(negedge clk_pix);
    check_output("reset_rgb", 32'(rgb), 32'h0);
    check_output("reset_de_o", 32'(de_o), 32'h0);
    check_output("reset_hsync_o", 32'(hsync_o), 32'h0);
    check_output("reset_vsync_o", 32'(vsync_o), 32'h0);
    check_output("reset_font_addr", 32'(font_addr), 32'h0);
    de = 1'b0; hsync = 1'b0; vsync = 1'b0; sx = -16'sd1;
    rst_n = 1'b1;

    // Fill the text buffer, cell 0 holds 'A' and cell 5 a space.
    for (int i = 0; i < NCELL; i++) begin
      s = idle_stim();
      s.wr_en = 1'b1; s.wr_addr = i;
      s.wr_data = (i == 0) ? 'h41 : (i == 5) ? 'h20 : int'($urandom_range(0, 255));
      apply_stimulus(s);
    end

    for (int x = 0; x < 64; x++) begin
      s = idle_stim();
      s.de = 1'b1; s.sx = x; s.sy = 0; s.line = 3; s.bitc = x / 8;
      apply_stimulus(s);
    end

    for (int i = 0; i < 8; i++) begin
      s = idle_stim();
      s.de = (bd[i] != 0); s.hs = 1'b1; s.sx = bx[i]; s.sy = by[i]; s.line = 3; s.bitc = 0;
      apply_stimulus(s);
    end

    // Same-edge write and read of cell 5, then a plain read.
    s = idle_stim();
    s.de = 1'b1; s.sx = 320; s.sy = 0; s.line = 3; s.bitc = 2;
    s.wr_en = 1'b1; s.wr_addr = 5; s.wr_data = 'h42;
    apply_stimulus(s);
    s.wr_en = 1'b0;
    apply_stimulus(s);

    s = idle_stim();
    s.wr_en = 1'b1; s.wr_addr = 63; s.wr_data = 'hFF;
    apply_stimulus(s);
    readback_all();

    // Mid-line reset while the pixel is lit.
    s = idle_stim();
    s.de = 1'b1; s.hs = 1'b1; s.sx = 3; s.sy = 0; s.line = 3; s.bitc = 0;
    repeat (5) apply_stimulus(s);
    #2;
    check_output("pre_reset_rgb", 32'(rgb), 32'(FG));
    rst_n = 1'b0;
    pix_q.delete();
    fa_q.delete();
    rises = 0;
    prev_vs = 1'b0;
    #1;
    check_output("async_reset_rgb", 32'(rgb), 32'h0);
    check_output("async_reset_de_o", 32'(de_o), 32'h0);
    check_output("async_reset_hsync_o", 32'(hsync_o), 32'h0);
    check_output("async_reset_font_addr", 32'(font_addr), 32'h0);
    de = 1'b0; hsync = 1'b0; vsync = 1'b0;
    repeat (3) @(negedge clk_pix);
    rst_n = 1'b1;
    readback_all();

    // Long vsync pulses with the cursor parked on cell (0,0).
    for (int p = 0; p < 32; p++) begin
      for (int k = 0; k < 7; k++) begin
        s = idle_stim();
        s.de = 1'b1; s.vs = (k < 5); s.line = 3;
        s.sx = int'($urandom_range(0, 63)); s.sy = int'($urandom_range(0, 87)); s.bitc = s.sx / 8;
        s.cur_en = 1'b1; s.cur_col = 0; s.cur_row = 0;
        apply_stimulus(s);
      end
    end

    for (int i = 0; i < 600; i++) begin
      s = idle_stim();
      s.de = ($urandom_range(0, 9) != 0);
      s.hs = 1'($urandom_range(0, 1));
      s.vs = ($urandom_range(0, 15) == 0);
      s.sx = int'($urandom_range(0, 899)) - 100;
      s.sy = int'($urandom_range(0, 599)) - 50;
      s.bitc = int'($urandom_range(0, 7));
      s.line = int'($urandom_range(0, 10));
      s.wr_en = ($urandom_range(0, 3) == 0);
      s.wr_addr = int'($urandom_range(0, 63));
      s.wr_data = int'($urandom_range(0, 255));
      s.cur_en = 1'($urandom_range(0, 1));
      s.cur_col = int'($urandom_range(0, 11));
      s.cur_row = int'($urandom_range(0, 6));
      apply_stimulus(s);
    end

    repeat (6) @(negedge clk_pix);
    #1;
    check_output("queue_drain", 32'(pix_q.size() + fa_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
